// File: rtl/audio_io_sched.sv
// Sample-rate I/O scheduler between the audio converters and the core.
// An input FIFO feeds the core's adcdata. An output FIFO collects the core's
// outport samples and is drained to the DAC on dac_req ticks. A PRIME/RUN
// state machine handles start-up and recovery after an underrun.
module audio_io_sched #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       adc_valid,
  input  logic [DWIDTH-1:0]          adc_sample,
  output logic [DWIDTH-1:0]          cpu_adcdata,
  input  logic                       cpu_in_ready,
  input  logic                       cpu_out_vld,
  input  logic [DWIDTH-1:0]          cpu_outport,
  input  logic                       dac_req,
  output logic                       dac_valid,
  output logic [DWIDTH-1:0]          dac_data,
  output logic [$clog2(DEPTH):0]     in_level,
  input  logic                       flags_clr,
  output logic                       in_ovf,
  output logic                       in_udf,
  output logic                       out_ovf,
  output logic                       dac_udf
);

  localparam int ADDRW = $clog2(DEPTH);
  localparam logic [ADDRW:0]   FULL_CNT  = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0]   PRIME_CNT = (ADDRW+1)'(PRIME_LVL);
  localparam logic [ADDRW-1:0] PTR_ONE   = ADDRW'(1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t            state;
  logic [DWIDTH-1:0] in_mem  [DEPTH];
  logic [DWIDTH-1:0] out_mem [DEPTH];
  logic [ADDRW-1:0]  in_wptr, in_rptr, out_wptr, out_rptr;
  logic [ADDRW:0]    in_cnt, out_cnt, out_cnt_nxt;
  logic              in_push, in_pop, out_push, out_pop, dac_empty_req;

  // Push/pop qualification; a full FIFO still accepts a push when it pops in the same cycle.
  always_comb begin
    in_pop        = cpu_in_ready && (in_cnt != '0);
    in_push       = adc_valid && ((in_cnt != FULL_CNT) || in_pop);
    out_pop       = dac_req && (state == RUN) && (out_cnt != '0);
    out_push      = cpu_out_vld && ((out_cnt != FULL_CNT) || out_pop);
    dac_empty_req = dac_req && (state == RUN) && (out_cnt == '0);
    out_cnt_nxt   = out_cnt + {{ADDRW{1'b0}}, out_push} - {{ADDRW{1'b0}}, out_pop};
  end

  assign cpu_adcdata = (in_cnt != '0) ? in_mem[in_rptr] : '0;
  assign in_level    = in_cnt;

  // Sample storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clock) begin
    if (in_push)  in_mem[in_wptr]   <= adc_sample;
    if (out_push) out_mem[out_wptr] <= cpu_outport;
  end

  // Input FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_wptr <= '0;
      in_rptr <= '0;
      in_cnt  <= '0;
    end else begin
      if (in_push) in_wptr <= in_wptr + PTR_ONE;
      if (in_pop)  in_rptr <= in_rptr + PTR_ONE;
      in_cnt <= in_cnt + {{ADDRW{1'b0}}, in_push} - {{ADDRW{1'b0}}, in_pop};
    end
  end

  // Output FIFO, PRIME/RUN state machine and registered DAC interface.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_cnt   <= '0;
      state     <= PRIME;
      dac_valid <= 1'b0;
      dac_data  <= '0;
    end else begin
      if (out_push) out_wptr <= out_wptr + PTR_ONE;
      if (out_pop)  out_rptr <= out_rptr + PTR_ONE;
      out_cnt   <= out_cnt_nxt;
      dac_valid <= dac_req;
      case (state)
        PRIME: begin
          if (dac_req) dac_data <= '0;
          if (out_cnt_nxt >= PRIME_CNT) state <= RUN;
        end
        RUN: begin
          // An empty FIFO on a tick holds the last sample and re-primes.
          if (out_pop)       dac_data <= out_mem[out_rptr];
          if (dac_empty_req) state    <= PRIME;
        end
        default: state <= PRIME;
      endcase
    end
  end

  // Sticky error flags; a set event in the clearing cycle takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ovf  <= 1'b0;
      in_udf  <= 1'b0;
      out_ovf <= 1'b0;
      dac_udf <= 1'b0;
    end else begin
      in_ovf  <= (in_ovf  && !flags_clr) || (adc_valid && !in_push);
      in_udf  <= (in_udf  && !flags_clr) || (cpu_in_ready && (in_cnt == '0));
      out_ovf <= (out_ovf && !flags_clr) || (cpu_out_vld && !out_push);
      dac_udf <= (dac_udf && !flags_clr) || dac_empty_req;
    end
  end

endmodule

// File: tb/tb_audio_io_sched.sv
// Directed bench for audio_io_sched: a vector table for the single-cycle
// behaviour plus hand-written sequences around asynchronous reset.
module tb_audio_io_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        adc_valid;
  logic [31:0] adc_sample;
  logic [31:0] cpu_adcdata;
  logic        cpu_in_ready;
  logic        cpu_out_vld;
  logic [31:0] cpu_outport;
  logic        dac_req;
  logic        dac_valid;
  logic [31:0] dac_data;
  logic [2:0]  in_level;
  logic        flags_clr;
  logic        in_ovf, in_udf, out_ovf, dac_udf;
  logic [3:0]  flags;

  int checks   = 0;
  int failures = 0;

  assign flags = {in_ovf, in_udf, out_ovf, dac_udf};

  audio_io_sched #(.DWIDTH(32), .DEPTH(4), .PRIME_LVL(2)) dut (
    .clock(clock), .reset(reset),
    .adc_valid(adc_valid), .adc_sample(adc_sample), .cpu_adcdata(cpu_adcdata),
    .cpu_in_ready(cpu_in_ready), .cpu_out_vld(cpu_out_vld), .cpu_outport(cpu_outport),
    .dac_req(dac_req), .dac_valid(dac_valid), .dac_data(dac_data),
    .in_level(in_level), .flags_clr(flags_clr),
    .in_ovf(in_ovf), .in_udf(in_udf), .out_ovf(out_ovf), .dac_udf(dac_udf)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        av;
    logic [31:0] as;
    logic        rdy;
    logic        ov;
    logic [31:0] op;
    logic        req;
    logic        clr;
    logic [31:0] e_ad;
    logic [2:0]  e_lvl;
    logic        e_dv;
    logic [31:0] e_dd;
    logic [3:0]  e_fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic av, input logic [31:0] as, input logic rdy,
                              input logic ov, input logic [31:0] op, input logic req,
                              input logic clr, input logic [31:0] e_ad, input logic [2:0] e_lvl,
                              input logic e_dv, input logic [31:0] e_dd, input logic [3:0] e_fl);
    vec_t v;
    v.av = av; v.as = as; v.rdy = rdy; v.ov = ov; v.op = op; v.req = req; v.clr = clr;
    v.e_ad = e_ad; v.e_lvl = e_lvl; v.e_dv = e_dv; v.e_dd = e_dd; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ad, input logic [2:0] lvl,
                           input logic dv, input logic [31:0] dd, input logic [3:0] fl);
    chk({tag, "_adcdata"}, cpu_adcdata, ad);
    chk({tag, "_in_level"}, {29'd0, in_level}, {29'd0, lvl});
    chk({tag, "_dac_valid"}, {31'd0, dac_valid}, {31'd0, dv});
    chk({tag, "_dac_data"}, dac_data, dd);
    chk({tag, "_flags"}, {28'd0, flags}, {28'd0, fl});
  endtask

  task automatic drive(input logic av, input logic [31:0] as, input logic rdy,
                       input logic ov, input logic [31:0] op, input logic req, input logic clr);
    adc_valid = av; adc_sample = as; cpu_in_ready = rdy;
    cpu_out_vld = ov; cpu_outport = op; dac_req = req; flags_clr = clr;
  endtask

  initial begin
    //            av as        rdy ov op        req clr  ad        lvl dv dd        flags
    // Basic input FIFO fill and drain
    tbl.push_back(mk(1, 32'h11, 0, 0, 32'h0,  0, 0, 32'h11, 3'd1, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(1, 32'h22, 0, 0, 32'h0,  0, 0, 32'h11, 3'd2, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(1, 32'h33, 0, 0, 32'h0,  0, 0, 32'h11, 3'd3, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'h22, 3'd2, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'h33, 3'd1, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    // Input overflow: fifth sample dropped
    tbl.push_back(mk(1, 32'hA1, 0, 0, 32'h0,  0, 0, 32'hA1, 3'd1, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(1, 32'hA2, 0, 0, 32'h0,  0, 0, 32'hA1, 3'd2, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(1, 32'hA3, 0, 0, 32'h0,  0, 0, 32'hA1, 3'd3, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(1, 32'hA4, 0, 0, 32'h0,  0, 0, 32'hA1, 3'd4, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(1, 32'hA5, 0, 0, 32'h0,  0, 0, 32'hA1, 3'd4, 0, 32'h0,  4'b1000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 1, 32'hA1, 3'd4, 0, 32'h0,  4'b0000));
    // Full FIFO with simultaneous push and pop
    tbl.push_back(mk(1, 32'hB1, 1, 0, 32'h0,  0, 0, 32'hA2, 3'd4, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'hA3, 3'd3, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'hA4, 3'd2, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'hB1, 3'd1, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    // Input underflow; set beats clear in the same cycle
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0100));
    tbl.push_back(mk(0, 32'h0,  1, 0, 32'h0,  0, 1, 32'h0,  3'd0, 0, 32'h0,  4'b0100));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 1, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    // PRIME tick, then prime with two samples and run
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hA,  0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hB,  0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hA,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 0, 32'h0,  3'd0, 0, 32'hA,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hB,  4'b0000));
    // Underrun: hold last sample, flag, back to PRIME (next tick gives 0)
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hB,  4'b0001));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'h0,  4'b0001));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  0, 1, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    // Output overflow, full push+pop, back-to-back ticks
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hC1, 0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hC2, 0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hC3, 0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hC4, 0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hC5, 0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0010));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hC6, 1, 0, 32'h0,  3'd0, 1, 32'hC1, 4'b0010));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hC2, 4'b0010));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hC3, 4'b0010));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hC4, 4'b0010));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hC6, 4'b0010));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hC6, 4'b0011));
    // Same-cycle tick and push on an empty RUN FIFO is an underrun
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hD1, 0, 1, 32'h0,  3'd0, 0, 32'hC6, 4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hD2, 0, 0, 32'h0,  3'd0, 0, 32'hC6, 4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hD1, 4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hD2, 4'b0000));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hD3, 1, 0, 32'h0,  3'd0, 1, 32'hD2, 4'b0001));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'h0,  4'b0001));
    tbl.push_back(mk(0, 32'h0,  0, 1, 32'hD4, 0, 0, 32'h0,  3'd0, 0, 32'h0,  4'b0001));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hD3, 4'b0001));
    tbl.push_back(mk(0, 32'h0,  0, 0, 32'h0,  1, 0, 32'h0,  3'd0, 1, 32'hD4, 4'b0001));

    // Reset state
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    #1;
    check_all("reset_async", 32'h0, 3'd0, 1'b0, 32'h0, 4'b0000);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_all("reset_idle", 32'h0, 3'd0, 1'b0, 32'h0, 4'b0000);

    // Table-driven vectors: drive one cycle, sample 1 time unit after the edge
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].av, tbl[i].as, tbl[i].rdy, tbl[i].ov, tbl[i].op, tbl[i].req, tbl[i].clr);
      @(posedge clock); #1;
      check_all($sformatf("row%0d", i), tbl[i].e_ad, tbl[i].e_lvl, tbl[i].e_dv,
                tbl[i].e_dd, tbl[i].e_fl);
    end

    // Reset mid-operation: three samples in each FIFO and a pending tick
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'hE1 + k, 0, 1, 32'hF1 + k, 0, 0);
      @(posedge clock); #1;
    end
    chk("mid_in_level", {29'd0, in_level}, 32'd3);
    chk("mid_adcdata", cpu_adcdata, 32'hE1);
    drive(0, 32'h0, 0, 0, 32'h0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("midreset_async", 32'h0, 3'd0, 1'b0, 32'h0, 4'b0000);
    @(posedge clock); #1;
    check_all("midreset_held", 32'h0, 3'd0, 1'b0, 32'h0, 4'b0000);
    reset = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0, 0, 0);
    @(posedge clock); #1;
    check_all("postreset_idle", 32'h0, 3'd0, 1'b0, 32'h0, 4'b0000);
    // Output FIFO was flushed and the FSM re-primed: a tick yields zero
    drive(0, 32'h0, 0, 0, 32'h0, 1, 0);
    @(posedge clock); #1;
    check_all("postreset_tick", 32'h0, 3'd0, 1'b1, 32'h0, 4'b0000);
    // Input FIFO was flushed: consuming now underflows
    drive(0, 32'h0, 1, 0, 32'h0, 0, 0);
    @(posedge clock); #1;
    check_all("postreset_udf", 32'h0, 3'd0, 1'b0, 32'h0, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
